// File: rtl/nios2_ocimem_pkg.sv
// Shared definitions for the OCI RAM arbiter: FSM states, jdo field positions,
// and the full-word byte-enable constant.
package nios2_ocimem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_J_ACC = 3'd1,
        ST_J_CAP = 3'd2,
        ST_C_ACC = 3'd3,
        ST_C_CAP = 3'd4
    } ocimem_state_t;

    localparam int JDO_RD_BIT    = 17;
    localparam int JDO_ADDR_LSB  = 18;
    localparam int JDO_WDATA_LSB = 3;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/nios2_ocimem_rr_arb.sv
// Two-requester round-robin arbiter (JTAG vs CPU). The last-grant register
// changes only on a grant; after reset it points at the CPU so JTAG wins first.
module nios2_ocimem_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_req_j,
    input  logic i_req_c,
    output logic o_gnt_j,
    output logic o_gnt_c
);

    logic r_last_j;

    always_comb begin
        o_gnt_j = i_en && i_req_j && (!i_req_c || !r_last_j);
        o_gnt_c = i_en && i_req_c && !o_gnt_j;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_j <= 1'b0;
        end else if (o_gnt_j || o_gnt_c) begin
            r_last_j <= o_gnt_j;
        end
    end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the OCI debug RAM between JTAG actions and the CPU debug slave.
// Build option OCIMEM_AUTOINC_EN: JTAG address post-increments after each J_ACC.
module nios2_ocimem_arbiter
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    input  logic              debugack,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic              cpu_waitrequest,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_readdatavalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output ocimem_state_t     o_dbg_state
);

    ocimem_state_t     r_state, w_next;
    logic              r_jpend, r_jrd;
    logic [ADDR_W-1:0] r_jaddr;
    logic [DATA_W-1:0] r_jwdata, r_mon_data, r_cpu_rdata;
    logic              r_mon_ready, r_mon_error, r_cpu_rdv;
    logic              w_gnt_j, w_gnt_c, w_cpu_req, w_pend_clr, w_any, w_accept;
    logic              w_unused_jdo;

    assign w_unused_jdo = ^{jdo[37:35], jdo[2:0]};
    assign w_cpu_req    = cpu_read | cpu_write;
    // The slot frees in the same cycle the FSM retires the command, so a pulse then is legal.
    assign w_pend_clr   = (r_state == ST_J_ACC && !r_jrd) || (r_state == ST_J_CAP);
    assign w_any        = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_accept     = w_any && debugack && !(r_jpend && !w_pend_clr);

    nios2_ocimem_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_en    (r_state == ST_IDLE),
        .i_req_j (r_jpend),
        .i_req_c (w_cpu_req),
        .o_gnt_j (w_gnt_j),
        .o_gnt_c (w_gnt_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_gnt_j) w_next = ST_J_ACC;
                      else if (w_gnt_c) w_next = ST_C_ACC;
            ST_J_ACC: w_next = r_jrd ? ST_J_CAP : ST_IDLE;
            ST_J_CAP: w_next = ST_IDLE;
            ST_C_ACC: w_next = cpu_write ? ST_IDLE : ST_C_CAP;
            ST_C_CAP: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_addr        = '0;
        ram_wren        = 1'b0;
        ram_byteen      = 4'h0;
        ram_wdata       = '0;
        cpu_waitrequest = 1'b1;
        case (r_state)
            ST_J_ACC: begin
                ram_addr   = r_jaddr;
                ram_wren   = !r_jrd;
                ram_byteen = BE_ALL;
                ram_wdata  = r_jwdata;
            end
            ST_C_ACC: begin
                ram_addr        = cpu_address;
                ram_wren        = cpu_write;
                ram_byteen      = cpu_byteenable;
                ram_wdata       = cpu_writedata;
                cpu_waitrequest = 1'b0;
            end
            default: ;
        endcase
    end

    // JTAG command slot and monitor registers; a newly accepted read clears ready even if a capture lands now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_jpend     <= 1'b0;
            r_jrd       <= 1'b0;
            r_jaddr     <= '0;
            r_jwdata    <= '0;
            r_mon_data  <= '0;
            r_mon_ready <= 1'b0;
            r_mon_error <= 1'b0;
        end else begin
            if (w_pend_clr) r_jpend <= 1'b0;
`ifdef OCIMEM_AUTOINC_EN
            if (r_state == ST_J_ACC) r_jaddr <= r_jaddr + 1'b1;
`endif
            if (r_state == ST_J_CAP) begin
                r_mon_data  <= ram_rdata;
                r_mon_ready <= 1'b1;
            end
            if (w_accept) begin
                r_mon_error <= 1'b0;
                if (take_action_ocimem_a) begin
                    r_jaddr <= jdo[JDO_ADDR_LSB +: ADDR_W];
                    if (jdo[JDO_RD_BIT]) begin
                        r_jpend     <= 1'b1;
                        r_jrd       <= 1'b1;
                        r_mon_ready <= 1'b0;
                    end
                end else if (take_no_action_ocimem_a) begin
                    r_jpend     <= 1'b1;
                    r_jrd       <= 1'b1;
                    r_mon_ready <= 1'b0;
                end else begin
                    r_jpend  <= 1'b1;
                    r_jrd    <= 1'b0;
                    r_jwdata <= jdo[JDO_WDATA_LSB +: DATA_W];
                end
            end else if (w_any) begin
                r_mon_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_rdata <= '0;
            r_cpu_rdv   <= 1'b0;
        end else begin
            r_cpu_rdv <= (r_state == ST_C_CAP);
            if (r_state == ST_C_CAP) r_cpu_rdata <= ram_rdata;
        end
    end

    assign MonDReg           = r_mon_data;
    assign monitor_ready     = r_mon_ready;
    assign monitor_error     = r_mon_error;
    assign cpu_readdata      = r_cpu_rdata;
    assign cpu_readdatavalid = r_cpu_rdv;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Bench for nios2_ocimem_arbiter: behavioural OCI RAM, CPU/JTAG drivers,
// CPU read-data scoreboard and hand-timed JTAG/contention/reset sequences.
module tb_nios2_ocimem_arbiter;
  import nios2_ocimem_pkg::*;

`ifdef OCIMEM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        take_action_ocimem_a = 1'b0, take_no_action_ocimem_a = 1'b0, take_action_ocimem_b = 1'b0;
  logic [37:0] jdo = '0;
  logic        debugack = 1'b1;
  logic [7:0]  cpu_address = '0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [3:0]  cpu_byteenable = '0;
  logic        cpu_waitrequest, cpu_readdatavalid, ram_wren, monitor_ready, monitor_error;
  logic [31:0] cpu_readdata, ram_wdata, MonDReg;
  logic [31:0] ram_rdata = '0;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_byteen;
  ocimem_state_t dbg_state;

  always #5 clk = ~clk;

  nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .take_action_ocimem_a(take_action_ocimem_a), .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b), .jdo(jdo), .debugack(debugack),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata), .cpu_readdatavalid(cpu_readdatavalid),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .MonDReg(MonDReg), .monitor_ready(monitor_ready),
    .monitor_error(monitor_error), .o_dbg_state(dbg_state)
  );

  // Behavioural single-port RAM, 1-cycle registered read, byte-enabled write.
  logic [31:0] mem [0:255];
  logic        init_mem = 1'b1;
  logic [7:0]  last_wr_addr = '0;
  int          wr_count = 0;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= {16'hA5A5, 8'h00, 8'(i)};
      wr_count <= 0;
    end else if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      last_wr_addr <= ram_addr;
      wr_count     <= wr_count + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
    logic [37:0] d = '0;
    d[25:18] = a;
    d[17]    = rd;
    return d;
  endfunction

  function automatic logic [37:0] jdo_wr(input logic [31:0] w);
    logic [37:0] d = '0;
    d[34:3] = w;
    return d;
  endfunction

  // kind: 0 = take_action_ocimem_a, 1 = take_no_action_ocimem_a, 2 = take_action_ocimem_b
  task automatic jtag(input int kind, input logic [37:0] d, input logic dack);
    jdo = d;
    debugack = dack;
    take_action_ocimem_a    = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2);
    @(negedge clk);
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    debugack = 1'b1;
  endtask

  task automatic wait_rdv(inout int lat);
    int n = 0;
    while (!cpu_readdatavalid && n < 20) begin
      @(negedge clk);
      lat++;
      n++;
    end
    check("rdv_seen", {31'b0, cpu_readdatavalid}, 32'd1);
    if (cpu_readdatavalid && exp_q.size() > 0) check("cpu_readdata", cpu_readdata, exp_q.pop_front());
  endtask

  task automatic cpu_access(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic [31:0] exp, output int lat);
    bit got = 1'b0;
    lat = 0;
    cpu_address = a; cpu_writedata = d; cpu_byteenable = be;
    cpu_write = wr; cpu_read = !wr;
    if (!wr) exp_q.push_back(exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (!cpu_waitrequest) begin
        got = 1'b1;
        break;
      end
    end
    check("cpu_grant", {31'b0, got}, 32'd1);
    @(negedge clk);
    lat++;
    cpu_read = 1'b0; cpu_write = 1'b0;
    if (!wr) wait_rdv(lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_waitreq"}, {31'b0, cpu_waitrequest}, 32'd1);
    check({tag, "_rdv"}, {31'b0, cpu_readdatavalid}, 32'd0);
    check({tag, "_rdata"}, cpu_readdata, 32'd0);
    check({tag, "_wren"}, {31'b0, ram_wren}, 32'd0);
    check({tag, "_mondreg"}, MonDReg, 32'd0);
    check({tag, "_ready"}, {31'b0, monitor_ready}, 32'd0);
    check({tag, "_error"}, {31'b0, monitor_error}, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    int wc;
    vecs[0] = '{1'b1, 8'h20, 32'h11223344, 4'hF, 32'h0};
    vecs[1] = '{1'b1, 8'h21, 32'hAABBCCDD, 4'hF, 32'h0};
    vecs[2] = '{1'b1, 8'h20, 32'h55667788, 4'b0101, 32'h0};
    vecs[3] = '{1'b0, 8'h20, 32'h0, 4'hF, 32'h11663388};
    vecs[4] = '{1'b0, 8'h21, 32'h0, 4'hF, 32'hAABBCCDD};
    vecs[5] = '{1'b1, 8'h21, 32'hFFFFFFFF, 4'b1000, 32'h0};
    vecs[6] = '{1'b0, 8'h21, 32'h0, 4'hF, 32'hFFBBCCDD};

    // Reset values, during and after reset
    @(negedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_held");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    // JTAG write of DEADBEEF to 0x10, then uncontended CPU read
    jtag(0, jdo_addr(8'h10, 1'b0), 1'b1);
    jtag(2, jdo_wr(32'hDEADBEEF), 1'b1);
    repeat (4) @(negedge clk);
    check("jwr_addr", {24'b0, last_wr_addr}, 32'h10);
    check("jwr_mem", mem[8'h10], 32'hDEADBEEF);
    cpu_access(1'b0, 8'h10, 32'h0, 4'hF, 32'hDEADBEEF, lat);
    check("cpu_rd_lat", lat, 32'd3);

    // Table-driven CPU writes/reads with byte enables
    foreach (vecs[i]) begin
      cpu_access(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].exp, lat);
      check(vecs[i].wr ? "tbl_wr_lat" : "tbl_rd_lat", lat, vecs[i].wr ? 32'd2 : 32'd3);
    end

    // JTAG read of 0x20 leaves the last grant with JTAG before the next reset
    jtag(0, jdo_addr(8'h20, 1'b1), 1'b1);
    repeat (4) @(negedge clk);
    check("jrd20_ready", {31'b0, monitor_ready}, 32'd1);
    check("jrd20_data", MonDReg, 32'h11663388);

    // Contention right after reset: JTAG first, CPU in the following IDLE
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    jtag(0, jdo_addr(8'h10, 1'b1), 1'b1);
    cpu_address = 8'h20; cpu_read = 1'b1; cpu_byteenable = 4'hF;
    exp_q.push_back(32'h11663388);
    @(negedge clk);
    check("cont_c2_state", 32'(dbg_state), 32'(ST_J_ACC));
    check("cont_c2_addr", {24'b0, ram_addr}, 32'h10);
    check("cont_c2_waitreq", {31'b0, cpu_waitrequest}, 32'd1);
    @(negedge clk);
    check("cont_c3_state", 32'(dbg_state), 32'(ST_J_CAP));
    @(negedge clk);
    check("cont_c4_state", 32'(dbg_state), 32'(ST_IDLE));
    check("cont_c4_ready", {31'b0, monitor_ready}, 32'd1);
    check("cont_c4_mondreg", MonDReg, 32'hDEADBEEF);
    @(negedge clk);
    check("cont_c5_state", 32'(dbg_state), 32'(ST_C_ACC));
    check("cont_c5_waitreq", {31'b0, cpu_waitrequest}, 32'd0);
    check("cont_c5_addr", {24'b0, ram_addr}, 32'h20);
    @(negedge clk);
    cpu_read = 1'b0;
    lat = 0;
    wait_rdv(lat);
    check("cont_rdv_lat", lat, 32'd1);

    // Pulse without debugack: dropped, error set, no RAM access
    wc = wr_count;
    jtag(1, '0, 1'b0);
    check("nodbg_error", {31'b0, monitor_error}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("nodbg_idle", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
    end
    check("nodbg_nowrite", wr_count, wc);
    jtag(0, jdo_addr(8'h21, 1'b0), 1'b1);
    check("legal_clears_error", {31'b0, monitor_error}, 32'd0);

    // Overrun during J_ACC, then a write pulse in J_CAP is accepted
    jtag(1, '0, 1'b1);
    @(negedge clk);
    jtag(1, '0, 1'b1);
    check("ovr_error", {31'b0, monitor_error}, 32'd1);
    check("ovr_state", 32'(dbg_state), 32'(ST_J_CAP));
    check("ovr_ready_low", {31'b0, monitor_ready}, 32'd0);
    jtag(2, jdo_wr(32'h0BADF00D), 1'b1);
    check("jcap_accept_error", {31'b0, monitor_error}, 32'd0);
    check("ovr_ready", {31'b0, monitor_ready}, 32'd1);
    check("ovr_mondreg", MonDReg, 32'hFFBBCCDD);
    repeat (4) @(negedge clk);
    check("jcap_wr_addr", {24'b0, last_wr_addr}, AUTOINC ? 32'h22 : 32'h21);
    check("jcap_wr_data", mem[AUTOINC ? 8'h22 : 8'h21], 32'h0BADF00D);

    // Address 0xFF: write then read (wraps to 0x00 with post-increment)
    jtag(0, jdo_addr(8'hFF, 1'b0), 1'b1);
    jtag(2, jdo_wr(32'hCAFEF00D), 1'b1);
    repeat (4) @(negedge clk);
    check("wrap_wr_addr", {24'b0, last_wr_addr}, 32'hFF);
    jtag(1, '0, 1'b1);
    repeat (4) @(negedge clk);
    check("wrap_ready", {31'b0, monitor_ready}, 32'd1);
    check("wrap_rd_data", MonDReg, AUTOINC ? 32'hA5A50000 : 32'hCAFEF00D);

    // Reset asserted during C_ACC of a CPU write
    wc = wr_count;
    cpu_address = 8'h30; cpu_writedata = 32'h12345678; cpu_byteenable = 4'hF; cpu_write = 1'b1;
    lat = 0;
    while (cpu_waitrequest && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rst_cacc_reached", {31'b0, cpu_waitrequest}, 32'd0);
    check("rst_cacc_wren", {31'b0, ram_wren}, 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    cpu_write = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_write_cnt", wr_count, wc);
    check("rst_no_write_mem", mem[8'h30], 32'hA5A50030);
    reset = 1'b0;
    @(negedge clk);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
